// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scan path.
// Holds the key map so every block that needs (row, col) -> hex agrees.
package keypad_pkg;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned CODE_W = 4;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } kp_state_e;

    typedef struct packed {
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } kp_pos_t;

    localparam logic [CODE_W-1:0] KEY_MAP [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Lowest-index closed (low) row wins when several rows are low together.
    function automatic logic [IDX_W-1:0] lowest_low_row(input logic [ROWS-1:0] row_n);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(ROWS) - 1; i >= 0; i--) begin
            if (!row_n[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [COLS-1:0] col_drive(input logic [IDX_W-1:0] col);
        return ~(COLS'(1) << col);
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad-side signal bundle: row sense in, column drive and key report out.
interface keypad_if;
    import keypad_pkg::*;

    logic [ROWS-1:0]   row_n;
    logic [COLS-1:0]   col_n;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              busy;

    modport master (
        input  row_n,
        output col_n,
        output key_code,
        output key_valid,
        output busy
    );

    modport slave (
        output row_n,
        input  col_n,
        input  key_code,
        input  key_valid,
        input  busy
    );

endinterface

// File: rtl/keypad_key_decode.sv
// Combinational (row, col) -> hex key code lookup.
module keypad_key_decode
    import keypad_pkg::*;
(
    input  logic [IDX_W-1:0]  i_row_idx,
    input  logic [IDX_W-1:0]  i_col_idx,
    output logic [CODE_W-1:0] o_key_c
);

    assign o_key_c = KEY_MAP[i_row_idx][i_col_idx];

endmodule

// File: rtl/keypad_scan_controller.sv
// 4x4 keypad scanner: rotates the column drive, freezes on a press, debounces
// press and release, and reports one key_valid pulse per keypress.
module keypad_scan_controller
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DWELL      = 6_000,
    parameter int unsigned DEBOUNCE_CYCLES = 120_000
) (
    input  logic       clk,
    input  logic       reset,
    keypad_if.master   kp
);

    localparam int unsigned DWELL_W = (SCAN_DWELL > 1)      ? $clog2(SCAN_DWELL)      : 1;
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DWELL - 1);
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

    kp_state_e          r_state,     w_state_nxt;
    kp_pos_t            r_pos,       w_pos_nxt;
    logic [DWELL_W-1:0] r_dwell,     w_dwell_nxt;
    logic [DB_W-1:0]    r_db,        w_db_nxt;
    logic [CODE_W-1:0]  r_key_code,  w_key_code_nxt;
    logic               r_key_valid, w_key_valid_nxt;
    logic [COLS-1:0]    r_col_n;
    logic               r_busy;

    logic               w_row_closed;
    logic [IDX_W-1:0]   w_next_col;
    logic [CODE_W-1:0]  w_key_c;

    keypad_key_decode u_decode (
        .i_row_idx (r_pos.row),
        .i_col_idx (r_pos.col),
        .o_key_c   (w_key_c)
    );

    assign w_row_closed = ~kp.row_n[r_pos.row];
    assign w_next_col   = IDX_W'(r_pos.col + IDX_W'(1));

    // Next-state, counters and report for the scan/debounce sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_pos_nxt       = r_pos;
        w_dwell_nxt     = r_dwell;
        w_db_nxt        = r_db;
        w_key_code_nxt  = r_key_code;
        w_key_valid_nxt = 1'b0;

        unique case (r_state)
            SCAN: begin
                if (r_dwell == DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    if (kp.row_n == '1) begin
                        w_pos_nxt.col = w_next_col;
                    end else begin
                        w_pos_nxt.row = lowest_low_row(kp.row_n);
                        w_db_nxt      = '0;
                        w_state_nxt   = DB_PRESS;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + DWELL_W'(1);
                end
            end
            DB_PRESS: begin
                if (!w_row_closed) begin
                    w_state_nxt = SCAN;
                    w_dwell_nxt = '0;
                    w_db_nxt    = '0;
                end else if (r_db == DB_LAST) begin
                    w_key_valid_nxt = 1'b1;
                    w_key_code_nxt  = w_key_c;
                    w_db_nxt        = '0;
                    w_state_nxt     = HELD;
                end else begin
                    w_db_nxt = r_db + DB_W'(1);
                end
            end
            HELD: begin
                if (!w_row_closed) begin
                    w_db_nxt    = '0;
                    w_state_nxt = DB_RELEASE;
                end
            end
            DB_RELEASE: begin
                if (w_row_closed) begin
                    w_db_nxt    = '0;
                    w_state_nxt = HELD;
                end else if (r_db == DB_LAST) begin
                    w_pos_nxt.col = w_next_col;
                    w_dwell_nxt   = '0;
                    w_db_nxt      = '0;
                    w_state_nxt   = SCAN;
                end else begin
                    w_db_nxt = r_db + DB_W'(1);
                end
            end
            default: begin
                w_state_nxt = SCAN;
            end
        endcase
    end

    // State and output registers; column drive and busy follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SCAN;
            r_pos       <= '0;
            r_dwell     <= '0;
            r_db        <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_col_n     <= col_drive(IDX_W'(0));
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pos       <= w_pos_nxt;
            r_dwell     <= w_dwell_nxt;
            r_db        <= w_db_nxt;
            r_key_code  <= w_key_code_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_col_n     <= col_drive(w_pos_nxt.col);
            r_busy      <= (w_state_nxt != SCAN);
        end
    end

    assign kp.col_n     = r_col_n;
    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
    assign kp.busy      = r_busy;

endmodule
